// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART transmitter.
// frame_len() gives the cycle count from capture edge to done edge.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam logic [UART_DATA_W-1:0] UART_TRAILER_DEFAULT = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } uart_state_e;

  function automatic int frame_len(input int t, input int stop_bits, input int gap_bits);
    return t * (9 + stop_bits) + (t - 1) * gap_bits;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit-level 8N1 engine: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// o_byte_done is high during the last stop cycle so a reload can follow back-to-back.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic                   txclk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic [UART_DATA_W-1:0] i_byte,
  output logic                   o_tx,
  output logic                   o_byte_done,
  output logic [2:0]             o_state
);

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  uart_state_e            r_state;
  uart_state_e            w_state_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] w_shift_nxt;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             w_bit_cnt_nxt;
  logic [1:0]             r_stop_cnt;
  logic [1:0]             w_stop_cnt_nxt;
  logic                   r_tx;
  logic                   w_tx_nxt;
  logic                   w_last_stop;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign w_last_stop = (r_state == ST_STOP) && (r_stop_cnt == STOP_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = r_tx;
    // A load wins over the final stop cycle, giving gapless byte chaining.
    if (i_load) begin
      w_state_nxt = ST_START;
      w_shift_nxt = i_byte;
      w_tx_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[UART_DATA_W-1:1]};
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = '0;
            w_state_nxt    = ST_STOP;
          end else begin
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[UART_DATA_W-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
        ST_STOP: begin
          if (w_last_stop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 2'd1;
          end
        end
        default: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx        = r_tx;
  assign o_byte_done = w_last_stop;
  assign o_state     = r_state;

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: sends NBYTES payload bytes MSB byte first, then an
// optional trailer byte, with GAP_BITS idle cycles between bytes of a frame.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int                     NBYTES       = 2,
  parameter int                     TRAILER_EN   = 1,
  parameter logic [UART_DATA_W-1:0] TRAILER_BYTE = UART_TRAILER_DEFAULT,
  parameter int                     STOP_BITS    = 1,
  parameter int                     GAP_BITS     = 1
) (
  input  logic                  reset,
  input  logic                  txclk,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   data_in,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            byte_idx,
  output logic [2:0]            dbg_state
);

  localparam int         NBYTES_TOT = NBYTES + TRAILER_EN;
  localparam int         FRAME_LEN  = frame_len(NBYTES_TOT, STOP_BITS, GAP_BITS);
  localparam logic [4:0] LAST_IDX   = 5'(NBYTES_TOT - 1);
  localparam logic [1:0] GAP_LAST   = 2'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  // ST_DATA here means "a byte is owned by the serializer" (start, data or stop).
  uart_state_e            r_state;
  uart_state_e            w_state_nxt;
  logic [8*NBYTES-1:0]    r_payload;
  logic [8*NBYTES-1:0]    w_sel_src;
  logic [4:0]             r_byte_idx;
  logic [4:0]             w_sel_idx;
  logic [UART_DATA_W-1:0] w_sel_byte;
  logic [1:0]             r_gap_cnt;
  logic [7:0]             r_frame_cyc;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_capture;
  logic                   w_load;
  logic                   w_advance;
  logic                   w_finish;
  logic                   w_gap_start;
  logic                   w_byte_done;
  logic [2:0]             w_ser_state;

  uart_tx_serializer #(
    .STOP_BITS (STOP_BITS)
  ) u_ser (
    .txclk       (txclk),
    .reset       (reset),
    .i_load      (w_load),
    .i_byte      (w_sel_byte),
    .o_tx        (tx_out),
    .o_byte_done (w_byte_done),
    .o_state     (w_ser_state)
  );

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_payload   <= '0;
      r_byte_idx  <= '0;
      r_gap_cnt   <= '0;
      r_frame_cyc <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (w_capture) begin
        r_payload   <= data_in;
        r_byte_idx  <= '0;
        r_busy      <= 1'b1;
        r_frame_cyc <= 8'd1;
      end else if (r_busy) begin
        r_frame_cyc <= r_frame_cyc + 8'd1;
      end
      if (w_advance) r_byte_idx <= r_byte_idx + 5'd1;
      if (w_finish)  r_busy     <= 1'b0;
      if (w_gap_start) begin
        r_gap_cnt <= '0;
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_gap_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_byte_done) begin
          if (r_byte_idx == LAST_IDX) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (GAP_BITS == 0) begin
            w_load    = 1'b1;
            w_advance = 1'b1;
          end else begin
            w_gap_start = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_load      = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The first byte comes straight from data_in since the payload register loads on the same edge.
  always_comb begin
    w_sel_src  = w_capture ? data_in : r_payload;
    w_sel_idx  = w_capture ? 5'd0 : (r_byte_idx + 5'd1);
    w_sel_byte = TRAILER_BYTE;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_sel_idx == 5'(b)) w_sel_byte = w_sel_src[8*(NBYTES-1-b) +: 8];
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign byte_idx  = r_byte_idx;
  assign dbg_state = (r_state == ST_DATA) ? w_ser_state : r_state;

  a_frame_len: assert property (@(posedge txclk) disable iff (reset)
    w_finish |-> (r_frame_cyc == 8'(FRAME_LEN)));

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: default frame config (A), a single-byte 2-stop no-gap
// config (B), and a 16x-oversampling 3-byte receiver model on A's line.
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int HALF = 16;
  localparam int LA   = frame_len(3, 1, 1);
  localparam int LB   = frame_len(1, 2, 0);

  logic        txclk = 1'b0;
  logic        rx_clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] data_a;
  logic [7:0]  data_b;
  logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [4:0]  idx_a, idx_b;
  logic [2:0]  dbg_a, dbg_b;

  // Scoreboard entries: {busy, done, tx_out, byte_idx} for every in-flight cycle.
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] mon_act_a, mon_act_b, mon_exp_a, mon_exp_b;
  int n_checks = 0;
  int n_failures = 0;

  // Receiver model state
  int          rx_st = 0, rx_cnt = 0, rx_bit = 0, rx_nbyte = 0, rx_frames = 0;
  logic [7:0]  rx_sh = '0, rx_hi = '0, rx_lo = '0, rx_trailer = '0;
  logic [15:0] rx_data_o = '0;

  always #HALF txclk = ~txclk;
  always #1 rx_clk = ~rx_clk;

  uart_tx_framed dut_a (
    .reset(reset), .txclk(txclk), .start(start_a), .data_in(data_a),
    .tx_out(tx_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a), .dbg_state(dbg_a)
  );

  uart_tx_framed #(
    .NBYTES(1), .TRAILER_EN(0), .STOP_BITS(2), .GAP_BITS(0)
  ) dut_b (
    .reset(reset), .txclk(txclk), .start(start_b), .data_in(data_b),
    .tx_out(tx_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b), .dbg_state(dbg_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input bit to_b, input logic [7:0] v);
    if (to_b) exp_b_q.push_back(v);
    else      exp_a_q.push_back(v);
  endtask

  // Expected per-cycle trace from capture edge k up to and including the done cycle.
  task automatic push_frame(input bit to_b, input logic [23:0] bytes, input int t,
                            input int stop_bits, input int gap_bits);
    logic [7:0] bv;
    logic [4:0] id;
    for (int i = 0; i < t; i++) begin
      bv = bytes[8*(t-1-i) +: 8];
      id = 5'(i);
      put(to_b, {1'b1, 1'b0, 1'b0, id});
      for (int n = 0; n < 8; n++) put(to_b, {1'b1, 1'b0, bv[n], id});
      for (int s = 0; s < stop_bits; s++) put(to_b, {1'b1, 1'b0, 1'b1, id});
      if (i < t - 1) for (int g = 0; g < gap_bits; g++) put(to_b, {1'b1, 1'b0, 1'b1, id});
    end
    put(to_b, {1'b0, 1'b1, 1'b1, 5'(t - 1)});
  endtask

  task automatic send_a(input logic [15:0] d);
    @(posedge txclk); #1; data_a = d; start_a = 1'b1;
    @(posedge txclk); push_frame(1'b0, {d, UART_TRAILER_DEFAULT}, 3, 1, 1);
    #1; start_a = 1'b0;
    repeat (LA) @(posedge txclk);
  endtask

  task automatic send_b(input logic [7:0] d);
    @(posedge txclk); #1; data_b = d; start_b = 1'b1;
    @(posedge txclk); push_frame(1'b1, {16'h0000, d}, 1, 2, 0);
    #1; start_b = 1'b0;
    repeat (LB) @(posedge txclk);
  endtask

  always @(negedge txclk) begin
    if (!reset) begin
      mon_act_a = {busy_a, done_a, tx_a, idx_a};
      if (busy_a || done_a || exp_a_q.size() != 0) begin
        if (exp_a_q.size() == 0) begin
          check("a_unexpected_activity", {busy_a, done_a}, 2'b00);
        end else begin
          mon_exp_a = exp_a_q.pop_front();
          check("a_frame_cycle", mon_act_a, mon_exp_a);
        end
      end else begin
        check("a_idle_line", tx_a, 1'b1);
      end
    end
  end

  always @(negedge txclk) begin
    if (!reset) begin
      mon_act_b = {busy_b, done_b, tx_b, idx_b};
      if (busy_b || done_b || exp_b_q.size() != 0) begin
        if (exp_b_q.size() == 0) begin
          check("b_unexpected_activity", {busy_b, done_b}, 2'b00);
        end else begin
          mon_exp_b = exp_b_q.pop_front();
          check("b_frame_cycle", mon_act_b, mon_exp_b);
        end
      end else begin
        check("b_idle_line", tx_b, 1'b1);
      end
    end
  end

  // 16x-oversampling hi/lo/trailer receiver at the matched rate.
  always @(posedge rx_clk) begin
    if (reset) begin
      rx_st = 0; rx_cnt = 0; rx_bit = 0; rx_nbyte = 0;
    end else begin
      case (rx_st)
        0: if (!tx_a) begin rx_st = 1; rx_cnt = 0; end
        1: begin
          rx_cnt++;
          if (rx_cnt == 7) begin
            rx_cnt = 0; rx_bit = 0;
            rx_st = (!tx_a) ? 2 : 0;
          end
        end
        2: begin
          rx_cnt++;
          if (rx_cnt == 16) begin
            rx_cnt = 0;
            rx_sh = {tx_a, rx_sh[7:1]};
            rx_bit++;
            if (rx_bit == 8) rx_st = 3;
          end
        end
        default: begin
          rx_cnt++;
          if (rx_cnt == 16) begin
            rx_st = 0;
            if (!tx_a) rx_nbyte = 0;
            else if (rx_nbyte == 0) begin rx_hi = rx_sh; rx_nbyte = 1; end
            else if (rx_nbyte == 1) begin rx_lo = rx_sh; rx_nbyte = 2; end
            else begin
              rx_trailer = rx_sh; rx_data_o = {rx_hi, rx_lo};
              rx_nbyte = 0; rx_frames++;
            end
          end
        end
      endcase
    end
  end

  initial begin
    int f0;
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    #3 reset = 1'b1;
    #2;
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_idx_a", idx_a, 5'd0);
    check("rst_state_a", dbg_a, ST_IDLE);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_state_b", dbg_b, ST_IDLE);
    repeat (2) @(posedge txclk);
    #4 reset = 1'b0;
    repeat (50) @(posedge txclk);

    send_a(16'hA55A);
    send_a(16'hFF01);

    // start held high through two frames, data changed while busy
    @(posedge txclk); #1; data_a = 16'h3CC3; start_a = 1'b1;
    @(posedge txclk); push_frame(1'b0, {16'h3CC3, UART_TRAILER_DEFAULT}, 3, 1, 1);
    repeat (5) @(posedge txclk); #1; data_a = 16'h0F0F;
    repeat (28) @(posedge txclk); push_frame(1'b0, {16'h0F0F, UART_TRAILER_DEFAULT}, 3, 1, 1);
    #1; data_a = 16'hFFFF;
    repeat (7) @(posedge txclk); #1; start_a = 1'b0;
    repeat (25) @(posedge txclk);

    send_b(8'h00);
    send_b(8'hC3);

    // reset mid byte 1
    @(posedge txclk); #1; data_a = 16'h6699; start_a = 1'b1;
    @(posedge txclk); push_frame(1'b0, {16'h6699, UART_TRAILER_DEFAULT}, 3, 1, 1);
    #1; start_a = 1'b0;
    repeat (13) @(posedge txclk);
    #4 reset = 1'b1;
    exp_a_q.delete();
    #1;
    check("midrst_tx_a", tx_a, 1'b1);
    check("midrst_busy_a", busy_a, 1'b0);
    check("midrst_done_a", done_a, 1'b0);
    repeat (2) @(posedge txclk);
    #4 reset = 1'b0;
    send_a(16'h1234);

    // loopback into the receiver model
    f0 = rx_frames;
    send_a(16'hBEEF);
    for (int i = 0; i < 40 && rx_frames == f0; i++) @(posedge txclk);
    check("rx_frame_count", rx_frames, f0 + 1);
    check("rx_data_o", rx_data_o, 16'hBEEF);
    check("rx_trailer", rx_trailer, UART_TRAILER_DEFAULT);

    repeat (4) @(posedge txclk);
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #(2 * HALF * 5000);
    n_checks++;
    n_failures++;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
